reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, meaning the data width in bits.
REQ-002 The block SHALL have parameter NREGS, default 32, meaning the register count (power of two, at least 4).
REQ-003 The block SHALL have parameter NRD, default 2, meaning the number of read ports (1..4).
REQ-004 The block SHALL derive constant AW = log2(NREGS) for the address width.
REQ-005 The block SHALL have port clk, input, 1 bit, the clock; all state updates on the rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-007 The block SHALL have port clr_req, input, 1 bit, a single-cycle pulse requesting a runtime clear of all registers.
REQ-008 The block SHALL have port ready, output, 1 bit; high when writes are accepted and reads are valid.
REQ-009 The block SHALL have ports we0 and we1, input, 1 bit each, the write enables.
REQ-010 The block SHALL have ports waddr0 and waddr1, input, AW bits each, the write addresses.
REQ-011 The block SHALL have ports wdata0 and wdata1, input, XLEN bits each, the write data.
REQ-012 The block SHALL have port raddr, input, NRD*AW bits; read address i occupies slice [i*AW +: AW].
REQ-013 The block SHALL have port rdata, output, NRD*XLEN bits; read data i occupies slice [i*XLEN +: XLEN].

Function
REQ-014 Register 0 SHALL always read as zero; writes to address 0 SHALL be discarded.
REQ-015 Reads SHALL be combinational with zero-cycle latency: rdata[i] = reg[raddr[i]] in the same cycle.
REQ-016 Write-through bypass SHALL apply when ready=1, wek=1, waddrk equals raddr[i], and the address is nonzero: rdata[i] returns wdatak in that cycle.
REQ-017 The block SHALL commit both writes on the same edge when waddr0 differs from waddr1.
REQ-018 When both ports write the same nonzero address, port 1 SHALL win for both the commit and the bypass.
REQ-019 The FSM SHALL have two states, CLEAR and RUN.
REQ-020 In CLEAR, a counter clr_idx SHALL step from 1 to NREGS-1, zeroing one register per cycle.
REQ-021 At the cycle in which clr_idx = NREGS-1, the FSM SHALL move to RUN.
REQ-022 The ready output SHALL be 1 only in RUN.
REQ-023 In CLEAR, writes SHALL be ignored, the bypass SHALL be disabled, and every rdata SHALL be 0.
REQ-024 clr_req in RUN SHALL move the FSM to CLEAR with clr_idx = 1 on the next edge; any write in the same cycle SHALL be dropped.
REQ-025 clr_req in CLEAR SHALL restart clr_idx at 1.
REQ-026 A full clear SHALL take exactly NREGS-1 cycles in CLEAR; ready SHALL rise on the following edge.

Reset
REQ-027 reset=1 SHALL put the FSM in CLEAR with clr_idx = 1, force ready = 0, and drive all rdata to 0.
REQ-028 reset SHALL take priority over clr_req and over writes.
REQ-029 reset asserted mid-clear SHALL restart the clear sequence from index 1.
REQ-030 Register contents SHALL NOT be zeroed by reset directly; the CLEAR sequence SHALL do it, so that a RAM mapping remains possible.

Structure
REQ-031 The FSM state enum and the default XLEN/NREGS constants SHALL live in the shared package cpu_pkg.
REQ-032 A single sub-module, rf_clear_fsm, SHALL own the state, clr_idx and ready, and SHALL export clr_we and clr_addr to the storage array.
REQ-033 The storage array SHALL have one combined write path, with clear-write muxed ahead of port 0 and port 1.

Verification
REQ-034 Hold reset 1 cycle, release -> ready=0 for 31 cycles then 1; every read returns 0 at that point.
REQ-035 Write we0=1, waddr0=5, wdata0=0xDEAD with raddr[0]=5 in the same cycle -> rdata[0]=0xDEAD in that cycle and on the next cycle.
REQ-036 Drive we0 with address 7 and data 0x11, and we1 with address 7 and data 0x22, in the same cycle -> bypass reads 0x22, and 0x22 is stored.
REQ-037 Write address 0 with data 0xFF -> raddr=0 reads 0 in that cycle and afterwards.
REQ-038 Load registers 1..31 with nonzero values, then pulse clr_req -> ready=0 for 31 cycles, writes are ignored during that time, and all registers read 0 afterwards.
REQ-039 Assert reset at clear cycle 10 -> clear restarts, and ready rises 31 cycles after reset is released.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file clear FSM states and default datapath sizes.
package cpu_pkg;

    localparam int unsigned XLEN_DEF  = 64;
    localparam int unsigned NREGS_DEF = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/reg_file_mp_if.sv
// Write/read/clear bus of the multi-port register file.
interface reg_file_mp_if
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic                  clr_req;
    logic                  ready;
    logic                  we0;
    logic                  we1;
    logic [AW-1:0]         waddr0;
    logic [AW-1:0]         waddr1;
    logic [XLEN-1:0]       wdata0;
    logic [XLEN-1:0]       wdata1;
    logic [NRD*AW-1:0]     raddr;
    logic [NRD*XLEN-1:0]   rdata;

    modport master (
        output clr_req, we0, we1, waddr0, waddr1, wdata0, wdata1, raddr,
        input  ready, rdata
    );

    modport slave (
        input  clr_req, we0, we1, waddr0, waddr1, wdata0, wdata1, raddr,
        output ready, rdata
    );

endinterface

// File: rtl/reg_file_mp_clear_fsm.sv
// Clear sequencer: walks registers 1..NREGS-1 zeroing one per cycle, then opens the file.
module rf_clear_fsm
    import cpu_pkg::*;
#(
    parameter  int unsigned NREGS = NREGS_DEF,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] IDX_FIRST = AW'(1);
    localparam logic [AW-1:0] IDX_LAST  = AW'(NREGS - 1);

    rf_state_e     state;
    logic [AW-1:0] clr_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_idx <= IDX_FIRST;
            ready   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_req) begin
                        clr_idx <= IDX_FIRST;
                    end else if (clr_idx == IDX_LAST) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + IDX_FIRST;
                    end
                end
                RUN: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_idx <= IDX_FIRST;
                        ready   <= 1'b0;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_idx <= IDX_FIRST;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

    // Register 0 is never stored, so the walk starting at 1 covers every live entry.
    assign clr_we   = (state == CLEAR);
    assign clr_addr = clr_idx;

endmodule

// File: rtl/reg_file_mp.sv
// Two-write, NRD-read register file with write-through bypass and a sequenced clear.
module reg_file_mp
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = 2
) (
    input  logic          clk,
    input  logic          reset,
    reg_file_mp_if.slave  bus
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];
    logic            clr_we;
    logic [AW-1:0]   clr_addr;
    logic            rd_en;
    logic            wen0;
    logic            wen1;

    rf_clear_fsm #(
        .NREGS (NREGS)
    ) u_clear_fsm (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (bus.clr_req),
        .ready    (bus.ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A clear request drops any write presented alongside it.
    assign rd_en = bus.ready && !reset;
    assign wen0  = rd_en && !bus.clr_req && bus.we0 && (bus.waddr0 != '0);
    assign wen1  = rd_en && !bus.clr_req && bus.we1 && (bus.waddr1 != '0);

    // Single write path: clear has priority, port 1 lands after port 0 so it wins collisions.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            regs[clr_addr] <= '0;
        end else begin
            if (wen0) begin
                regs[bus.waddr0] <= bus.wdata0;
            end
            if (wen1) begin
                regs[bus.waddr1] <= bus.wdata1;
            end
        end
    end

    always_comb begin
        logic [AW-1:0] ra;
        ra        = '0;
        bus.rdata = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = bus.raddr[i*AW +: AW];
            if (rd_en && (ra != '0)) begin
                if (bus.we1 && (bus.waddr1 == ra)) begin
                    bus.rdata[i*XLEN +: XLEN] = bus.wdata1;
                end else if (bus.we0 && (bus.waddr0 == ra)) begin
                    bus.rdata[i*XLEN +: XLEN] = bus.wdata0;
                end else begin
                    bus.rdata[i*XLEN +: XLEN] = regs[ra];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp against an array-based reference model.
module tb_reg_file_mp;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned AW    = $clog2(NREGS);

    typedef struct packed {
        logic                rdy;
        logic [NRD*XLEN-1:0] rd;
    } exp_t;

    logic clk;
    logic reset;

    reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register contents plus number of clear cycles still owed.
    logic [XLEN-1:0] mem [NREGS];
    int              clear_left;
    exp_t            exp_q [$];
    int              n_pass;
    int              n_total;

    function automatic void chk(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] req);
        n_total++;
        if (act !== req) begin
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end else begin
            n_pass++;
        end
    endfunction

    function automatic exp_t predict();
        exp_t            e;
        logic [AW-1:0]   a;
        logic [XLEN-1:0] v;
        e.rdy = (clear_left == 0);
        e.rd  = '0;
        if (e.rdy && !reset) begin
            for (int i = 0; i < NRD; i++) begin
                a = bus.raddr[i*AW +: AW];
                v = '0;
                if (a != '0) begin
                    v = mem[a];
                    if (bus.we0 && bus.waddr0 == a) v = bus.wdata0;
                    if (bus.we1 && bus.waddr1 == a) v = bus.wdata1;
                end
                e.rd[i*XLEN +: XLEN] = v;
            end
        end
        return e;
    endfunction

    function automatic void model_update();
        if (reset || bus.clr_req) begin
            clear_left = NREGS - 1;
        end else if (clear_left > 0) begin
            mem[NREGS - clear_left] = '0;
            clear_left--;
        end else begin
            if (bus.we0 && bus.waddr0 != '0) mem[bus.waddr0] = bus.wdata0;
            if (bus.we1 && bus.waddr1 != '0) mem[bus.waddr1] = bus.wdata1;
        end
    endfunction

    task automatic step();
        exp_q.push_back(predict());
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.clr_req = 1'b0;
        bus.we0     = 1'b0;
        bus.we1     = 1'b0;
        bus.waddr0  = '0;
        bus.waddr1  = '0;
        bus.wdata0  = '0;
        bus.wdata1  = '0;
        bus.raddr   = '0;
    endtask

    task automatic set_read(int port, int a);
        bus.raddr[port*AW +: AW] = AW'(a);
    endtask

    task automatic rand_inputs(bit allow_ctl);
        bus.we0    = 1'($urandom_range(0, 1));
        bus.we1    = 1'($urandom_range(0, 1));
        bus.waddr0 = AW'($urandom_range(0, NREGS - 1));
        bus.waddr1 = ($urandom_range(0, 3) == 0) ? bus.waddr0 : AW'($urandom_range(0, NREGS - 1));
        bus.wdata0 = {$urandom, $urandom};
        bus.wdata1 = {$urandom, $urandom};
        for (int i = 0; i < NRD; i++) begin
            case ($urandom_range(0, 3))
                0:       bus.raddr[i*AW +: AW] = bus.waddr0;
                1:       bus.raddr[i*AW +: AW] = bus.waddr1;
                default: bus.raddr[i*AW +: AW] = AW'($urandom_range(0, NREGS - 1));
            endcase
        end
        bus.clr_req = allow_ctl && ($urandom_range(0, 149) == 0);
        reset       = allow_ctl && ($urandom_range(0, 399) == 0);
    endtask

    // Counts cycles until ready rises, bounded so a stuck FSM still reaches the summary.
    task automatic wait_ready(input bit rnd_w, output int n);
        n = 0;
        while (!bus.ready && n < 200) begin
            if (rnd_w) rand_inputs(1'b0);
            else begin
                set_idle();
                set_read(0, $urandom_range(0, NREGS - 1));
                set_read(1, $urandom_range(0, NREGS - 1));
            end
            step();
            n++;
        end
        set_idle();
    endtask

    task automatic scan_all();
        for (int a = 0; a < NREGS; a++) begin
            set_idle();
            set_read(0, a);
            set_read(1, NREGS - 1 - a);
            step();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ready", XLEN'(bus.ready), XLEN'(e.rdy));
            for (int i = 0; i < NRD; i++) begin
                chk($sformatf("rdata[%0d]", i), bus.rdata[i*XLEN +: XLEN], e.rd[i*XLEN +: XLEN]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        int n;
        n_pass     = 0;
        n_total    = 0;
        clear_left = NREGS - 1;
        for (int a = 0; a < NREGS; a++) mem[a] = '0;
        set_idle();

        // Power-up: one reset cycle, then the full clear sequence.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_ready(1'b0, n);
        chk("reset_clear_len", XLEN'(n), XLEN'(NREGS - 1));
        scan_all();

        // Same-cycle bypass, then the committed value.
        set_idle();
        bus.we0 = 1'b1; bus.waddr0 = AW'(5); bus.wdata0 = 64'hDEAD;
        set_read(0, 5);
        step();
        set_idle();
        set_read(0, 5);
        step();

        // Collision on address 7: port 1 wins.
        set_idle();
        bus.we0 = 1'b1; bus.waddr0 = AW'(7); bus.wdata0 = 64'h11;
        bus.we1 = 1'b1; bus.waddr1 = AW'(7); bus.wdata1 = 64'h22;
        set_read(0, 7);
        set_read(1, 7);
        step();
        set_idle();
        set_read(1, 7);
        step();

        // Address 0 is hardwired to zero.
        set_idle();
        bus.we0 = 1'b1; bus.waddr0 = '0; bus.wdata0 = 64'hFF;
        bus.we1 = 1'b1; bus.waddr1 = '0; bus.wdata1 = 64'hFF;
        step();
        set_idle();
        step();

        // Fill, then a runtime clear with writes hammering during it.
        for (int a = 1; a < NREGS; a++) begin
            set_idle();
            bus.we0 = 1'b1; bus.waddr0 = AW'(a); bus.wdata0 = {$urandom, 32'(a) | 32'h1};
            set_read(0, a);
            step();
        end
        scan_all();
        set_idle();
        bus.clr_req = 1'b1;
        bus.we0 = 1'b1; bus.waddr0 = AW'(3); bus.wdata0 = 64'h3333;
        step();
        wait_ready(1'b1, n);
        chk("runtime_clear_len", XLEN'(n), XLEN'(NREGS - 1));
        scan_all();

        // Reset landing on clear cycle 10 restarts the sequence.
        for (int a = 1; a < NREGS; a += 3) begin
            set_idle();
            bus.we1 = 1'b1; bus.waddr1 = AW'(a); bus.wdata1 = {$urandom, $urandom};
            step();
        end
        set_idle();
        bus.clr_req = 1'b1;
        step();
        for (int c = 1; c < 10; c++) begin
            rand_inputs(1'b0);
            step();
        end
        set_idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_ready(1'b0, n);
        chk("reset_mid_clear_len", XLEN'(n), XLEN'(NREGS - 1));
        scan_all();

        // Random traffic with occasional clears and resets.
        for (int c = 0; c < 800; c++) begin
            rand_inputs(1'b1);
            step();
        end
        reset = 1'b0;
        set_idle();
        wait_ready(1'b0, n);
        scan_all();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
